// File: rtl/utf8_stream_decoder_pkg.sv
// utf8_pkg: shared types, constants and lead-byte helpers for the UTF-8 stream decoder.
package utf8_pkg;
   typedef enum logic {IDLE, CONT} state_e;
   localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
   typedef enum logic [2:0] {CLS_ASCII, CLS_CONT, CLS_LEAD2, CLS_LEAD3, CLS_LEAD4, CLS_INVALID} byte_class_e;
   function automatic byte_class_e byte_class(input logic [7:0] b);
      return b < 8'h80 ? CLS_ASCII :
             b < 8'hC0 ? CLS_CONT :
             b < 8'hC2 ? CLS_INVALID :
             b < 8'hE0 ? CLS_LEAD2 :
             b < 8'hF0 ? CLS_LEAD3 :
             b < 8'hF5 ? CLS_LEAD4 : CLS_INVALID;
   endfunction
   // 0 marks a byte that cannot start a sequence.
   function automatic logic [2:0] lead_len(input logic [7:0] b);
      byte_class_e c;
      c = byte_class(b);
      return c == CLS_ASCII ? 3'd1 :
             c == CLS_LEAD2 ? 3'd2 :
             c == CLS_LEAD3 ? 3'd3 :
             c == CLS_LEAD4 ? 3'd4 : 3'd0;
   endfunction
endpackage

// File: rtl/utf8_stream_decoder_classify.sv
// utf8_lead_classify: lead byte -> sequence length, initial payload and second-byte bounds.
// UTF8_DEC_SURROGATE_PASS_EN widens the ED second-byte range so surrogates pass through.
module utf8_lead_classify
   import utf8_pkg::*;
(
   input  logic [7:0]  lead,
   output logic [2:0]  len,
   output logic [20:0] payload,
   output logic [7:0]  lo,
   output logic [7:0]  hi
);
   always_comb begin
      len = lead_len(lead);
      payload = len == 3'd2 ? {16'd0, lead[4:0]} :
                len == 3'd3 ? {17'd0, lead[3:0]} :
                len == 3'd4 ? {18'd0, lead[2:0]} : {14'd0, lead[6:0]};
      lo = lead == 8'hE0 ? 8'hA0 : lead == 8'hF0 ? 8'h90 : 8'h80;
`ifdef UTF8_DEC_SURROGATE_PASS_EN
      hi = lead == 8'hF4 ? 8'h8F : 8'hBF;
`else
      hi = lead == 8'hED ? 8'h9F : lead == 8'hF4 ? 8'h8F : 8'hBF;
`endif
   end
endmodule

// File: rtl/utf8_stream_decoder.sv
// utf8_stream_decoder: byte-serial UTF-8 decoder emitting one scalar (or U+FFFD) per maximal subpart.
// Define UTF8_DEC_SURROGATE_PASS_EN to accept encoded surrogates (WTF-8 input).
module utf8_stream_decoder
   import utf8_pkg::*;
#(
   parameter logic [20:0] REPLACEMENT = REPLACEMENT_CP
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_flush,
   output logic [20:0] out_cp,
   output logic [2:0]  out_len,
   output logic        out_err,
   output logic        out_valid,
   input  logic        out_ready
);
   state_e      state_q, state_d;
   logic [20:0] acc_q, acc_d, acc_nx, out_cp_q, out_cp_d, lead_pl;
   logic [1:0]  rem_q, rem_d;
   logic [2:0]  len_q, len_d, out_len_q, out_len_d, lead_n;
   logic [7:0]  lo_q, lo_d, hi_q, hi_d, lead_lo, lead_hi;
   logic        out_err_q, out_err_d, out_valid_q, out_valid_d;
   logic        can_load, stall, fire;
   utf8_lead_classify u_cls (
      .lead    (in_data),
      .len     (lead_n),
      .payload (lead_pl),
      .lo      (lead_lo),
      .hi      (lead_hi)
   );
   assign can_load  = !out_valid_q || out_ready;
   // A byte outside the expected range ends the sequence and is re-examined as a lead next cycle.
   assign stall     = state_q == CONT && in_valid && (in_data < lo_q || in_data > hi_q);
   assign in_ready  = can_load && !stall;
   assign fire      = in_valid && in_ready;
   assign acc_nx    = {acc_q[14:0], in_data[5:0]};
   assign out_cp    = out_cp_q;
   assign out_len   = out_len_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      rem_d = rem_q;
      len_d = len_q;
      lo_d = lo_q;
      hi_d = hi_q;
      out_valid_d = out_valid_q && !out_ready;
      out_cp_d = out_cp_q;
      out_len_d = out_len_q;
      out_err_d = out_err_q;
      if (state_q == IDLE) begin
         if (fire && lead_n < 3'd2) begin
            out_valid_d = 1'b1;
            out_cp_d = lead_n == 3'd1 ? lead_pl : REPLACEMENT;
            out_len_d = 3'd1;
            out_err_d = lead_n == 3'd0;
         end else if (fire) begin
            state_d = CONT;
            acc_d = lead_pl;
            rem_d = 2'(lead_n - 3'd1);
            len_d = lead_n;
            lo_d = lead_lo;
            hi_d = lead_hi;
         end
      end else if (fire) begin
         acc_d = acc_nx;
         rem_d = rem_q - 2'd1;
         lo_d = 8'h80;
         hi_d = 8'hBF;
         if (rem_q == 2'd1) begin
            state_d = IDLE;
            out_valid_d = 1'b1;
            out_cp_d = acc_nx;
            out_len_d = len_q;
            out_err_d = 1'b0;
         end
      end else if (can_load && (stall || (!in_valid && in_flush))) begin
         state_d = IDLE;
         acc_d = '0;
         rem_d = '0;
         lo_d = 8'h80;
         hi_d = 8'hBF;
         out_valid_d = 1'b1;
         out_cp_d = REPLACEMENT;
         out_len_d = 3'(len_q - {1'b0, rem_q});
         out_err_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         rem_q <= '0;
         len_q <= '0;
         lo_q <= 8'h80;
         hi_q <= 8'hBF;
         out_valid_q <= 1'b0;
         out_cp_q <= '0;
         out_len_q <= '0;
         out_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         rem_q <= rem_d;
         len_q <= len_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
         out_valid_q <= out_valid_d;
         out_cp_q <= out_cp_d;
         out_len_q <= out_len_d;
         out_err_q <= out_err_d;
      end
   end
endmodule

// File: tb/tb_utf8_stream_decoder.sv
// tb_utf8_stream_decoder: directed self-checking bench for utf8_stream_decoder.
module tb_utf8_stream_decoder;
   import utf8_pkg::*;
   logic        clk = 0, rst = 1;
   logic [7:0]  in_data = 0;
   logic        in_valid = 0, in_flush = 0, out_ready = 1;
   logic        in_ready, out_err, out_valid;
   logic [20:0] out_cp;
   logic [2:0]  out_len;
   logic [24:0] q[$];
   int          n_checks = 0, n_fail = 0;
   utf8_stream_decoder dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_flush(in_flush), .out_cp(out_cp), .out_len(out_len), .out_err(out_err),
      .out_valid(out_valid), .out_ready(out_ready)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (!rst && out_valid && out_ready) q.push_back({out_cp, out_len, out_err});
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [7:0] b, output int stalls);
      stalls = 0;
      in_data = b;
      in_valid = 1;
      #1;
      while (!in_ready && stalls < 20) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(negedge clk);
      in_valid = 0;
   endtask
   task automatic send_seq(input logic [7:0] b[$]);
      int s;
      foreach (b[i]) send(b[i], s);
   endtask
   task automatic expect_out(input string tag, input logic [20:0] cp, input logic [2:0] len, input logic err);
      int n;
      logic [24:0] v;
      n = 0;
      while (q.size() == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() == 0) check({tag, "_timeout"}, 0, 1);
      else begin
         v = q.pop_front();
         check({tag, "_cp"}, 32'(v[24:4]), 32'(cp));
         check({tag, "_len"}, 32'(v[3:1]), 32'(len));
         check({tag, "_err"}, 32'(v[0]), 32'(err));
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int s;
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_cp", 32'(out_cp), 0);
      check("rst_out_len", 32'(out_len), 0);
      check("rst_out_err", 32'(out_err), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      send_seq('{8'h41, 8'hC3, 8'hA9, 8'hE2, 8'h82, 8'hAC, 8'hF0, 8'h9F, 8'h98, 8'h80});
      expect_out("t1_ascii", 21'h000041, 3'd1, 1'b0);
      expect_out("t1_two", 21'h0000E9, 3'd2, 1'b0);
      expect_out("t1_three", 21'h0020AC, 3'd3, 1'b0);
      expect_out("t1_four", 21'h01F600, 3'd4, 1'b0);
      send_seq('{8'hC0, 8'h80, 8'hF5});
      expect_out("t2_c0", 21'h00FFFD, 3'd1, 1'b1);
      expect_out("t2_80", 21'h00FFFD, 3'd1, 1'b1);
      expect_out("t2_f5", 21'h00FFFD, 3'd1, 1'b1);
      send_seq('{8'hE2, 8'h82});
      send(8'h41, s);
      check("t3_stall_cycles", 32'(s), 1);
      expect_out("t3_trunc", 21'h00FFFD, 3'd2, 1'b1);
      expect_out("t3_lead", 21'h000041, 3'd1, 1'b0);
      send_seq('{8'hED, 8'hA0, 8'h80});
`ifdef UTF8_DEC_SURROGATE_PASS_EN
      expect_out("t4_surr", 21'h00D800, 3'd3, 1'b0);
`else
      expect_out("t4_ed", 21'h00FFFD, 3'd1, 1'b1);
      expect_out("t4_a0", 21'h00FFFD, 3'd1, 1'b1);
      expect_out("t4_80", 21'h00FFFD, 3'd1, 1'b1);
`endif
      send_seq('{8'hF0, 8'h9F});
      in_flush = 1;
      @(negedge clk);
      in_flush = 0;
      expect_out("t5_flush", 21'h00FFFD, 3'd2, 1'b1);
      send(8'h41, s);
      expect_out("t5_after", 21'h000041, 3'd1, 1'b0);
      in_flush = 1;
      repeat (2) @(negedge clk);
      in_flush = 0;
      repeat (3) @(negedge clk);
      check("t5_idle_flush_noop", 32'(q.size()), 0);
      out_ready = 0;
      send(8'h41, s);
      in_data = 8'h42;
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t6_hold_cp", 32'(out_cp), 32'h41);
         check("t6_hold_valid", 32'(out_valid), 1);
         check("t6_in_ready", 32'(in_ready), 0);
         @(negedge clk);
      end
      check("t6_no_early_out", 32'(q.size()), 0);
      out_ready = 1;
      in_valid = 0;
      send_seq('{8'h42, 8'h43});
      expect_out("t6_a", 21'h000041, 3'd1, 1'b0);
      expect_out("t6_b", 21'h000042, 3'd1, 1'b0);
      expect_out("t6_c", 21'h000043, 3'd1, 1'b0);
      send_seq('{8'hE2, 8'h82});
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
      check("t6_rst_valid", 32'(out_valid), 0);
      repeat (3) @(negedge clk);
      check("t6_rst_no_out", 32'(q.size()), 0);
      send(8'h41, s);
      expect_out("t6_post_rst", 21'h000041, 3'd1, 1'b0);
      repeat (3) @(negedge clk);
      check("extra_outputs", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
